spectral_flux: RTL and testbench

Frame-based spectral flux engine fed by the FFT magnitude-squared stage. It consumes one unsigned magnitude-squared value per FFT bin and keeps the previous frame's magnitudes in an internal RAM. For each bin it computes the half-wave-rectified increase over the previous frame, and emits one flux sum per completed frame. The output feeds the onset/BPM detection logic downstream.

---
 rtl/spectral_flux.sv | 166 ++++++++++++++++
 tb/tb_spectral_flux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_flux.sv
// spectral_flux: per-frame spectral flux over the magnitude-squared spectrum.
// Each bin's rectified increase over the same bin of the previous frame is
// accumulated over bins 0..SUM_BINS-1 and one flux value is emitted per frame.
// Pipeline: input register -> S0 (RAM read) -> S1 (diff, RAM write) -> S2 (sum).
module spectral_flux #(
  parameter int MAG_W    = 33,
  parameter int N_BINS   = 512,
  parameter int SUM_BINS = 256,
  parameter int ACC_W    = MAG_W + $clog2(SUM_BINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MAG_W-1:0] mag_sq,
  input  logic             mag_valid,
  input  logic             mag_sop,
  output logic [ACC_W-1:0] flux,
  output logic             flux_valid,
  output logic             frame_err
);

  localparam int                BIN_W    = $clog2(N_BINS);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(N_BINS - 1);

  // Bin counter and frame-restart detection
  logic [BIN_W-1:0] r_bin;
  logic             r_frame_err;
  logic             w_sop_accept;
  logic             w_restart_err;
  logic [BIN_W-1:0] w_tag_bin;

  // Input register stage
  logic             r_in_valid;
  logic [BIN_W-1:0] r_in_bin;
  logic [MAG_W-1:0] r_in_mag;
  logic             r_in_first;
  logic             r_in_last;

  // S0: RAM read result alongside the sample
  logic             r_s0_valid;
  logic [BIN_W-1:0] r_s0_bin;
  logic [MAG_W-1:0] r_s0_mag;
  logic             r_s0_first;
  logic             r_s0_last;
  logic [MAG_W-1:0] r_prev;

  // Previous-frame magnitudes, one entry per bin
  logic [MAG_W-1:0] r_ram [N_BINS];

  // S1: rectified, masked difference
  logic             w_in_sum;
  logic [MAG_W-1:0] w_diff;
  logic             r_s1_valid;
  logic [MAG_W-1:0] r_s1_diff;
  logic             r_s1_first;
  logic             r_s1_last;

  // S2: accumulation and output
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_flux_sum;
  logic [ACC_W-1:0] r_flux;
  logic             r_flux_valid;
  logic             r_primed;

  // A sop always tags bin 0; a sop away from bin 0 abandons the open frame.
  assign w_sop_accept  = mag_valid & mag_sop;
  assign w_tag_bin     = w_sop_accept ? '0 : r_bin;
  assign w_restart_err = w_sop_accept & (r_bin != '0);

  // Tag each accepted sample with its bin and register it into the pipeline
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    if (reset) begin
      r_bin       <= '0;
      r_in_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_restart_err;
      r_in_valid  <= mag_valid;
      if (mag_valid) begin
        r_bin      <= w_tag_bin + BIN_W'(1);
        r_in_bin   <= w_tag_bin;
        r_in_mag   <= mag_sq;
        r_in_first <= (w_tag_bin == '0);
        r_in_last  <= (w_tag_bin == LAST_BIN);
      end
    end
  end

  // S0: carry the sample forward while the RAM read is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_valid <= 1'b0;
    end else begin
      r_s0_valid <= r_in_valid;
      r_s0_bin   <= r_in_bin;
      r_s0_mag   <= r_in_mag;
      r_s0_first <= r_in_first;
      r_s0_last  <= r_in_last;
    end
  end

  // Previous-frame RAM: read in S0, overwrite the same bin in S1
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; the first full frame after reset or a
    // frame error seeds every bin before any flux is emitted.
    r_prev <= r_ram[r_in_bin];
    if (r_s0_valid && !reset) begin
      r_ram[r_s0_bin] <= r_s0_mag;
    end
  end

  // Half-wave rectified increase, zeroed outside the summed bin range
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    w_in_sum = (32'(r_s0_bin) < 32'(SUM_BINS));
    w_diff   = '0;
    if (w_in_sum && (r_s0_mag > r_prev)) begin
      w_diff = r_s0_mag - r_prev;
    end
  end

  // S1: register the difference and its frame-position tags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s0_valid;
      r_s1_diff  <= w_diff;
      r_s1_first <= r_s0_first;
      r_s1_last  <= r_s0_last;
    end
  end

  assign w_flux_sum = r_acc + ACC_W'(r_s1_diff);

  // S2: accumulate the frame and publish flux on its last bin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_flux       <= '0;
      r_flux_valid <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_flux_valid <= 1'b0;
      if (r_s1_valid) begin
        r_acc <= r_s1_first ? ACC_W'(r_s1_diff) : w_flux_sum;
        if (r_s1_last) begin
          r_flux       <= w_flux_sum;
          r_flux_valid <= r_primed;
          r_primed     <= 1'b1;
        end
      end
      // A restart wins over a frame completing on the same edge.
      if (w_restart_err) begin
        r_primed <= 1'b0;
      end
    end
  end

  assign flux       = r_flux;
  assign flux_valid = r_flux_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_spectral_flux.sv
// tb_spectral_flux: directed scenarios plus randomized frames checked against
// a frame-level reference model (previous-frame array, plain sums).
module tb_spectral_flux;

  localparam int MAG_W    = 33;
  localparam int N_BINS   = 8;
  localparam int SUM_BINS = 4;
  localparam int ACC_W    = MAG_W + $clog2(SUM_BINS);

  typedef struct {
    longint unsigned at;
    longint unsigned val;
  } ev_t;

  logic             clk;
  logic             reset;
  logic [MAG_W-1:0] mag_sq;
  logic             mag_valid;
  logic             mag_sop;
  logic [ACC_W-1:0] flux;
  logic             flux_valid;
  logic             frame_err;

  spectral_flux #(
    .MAG_W    (MAG_W),
    .N_BINS   (N_BINS),
    .SUM_BINS (SUM_BINS),
    .ACC_W    (ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mag_sq     (mag_sq),
    .mag_valid  (mag_valid),
    .mag_sop    (mag_sop),
    .flux       (flux),
    .flux_valid (flux_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_errors = 0;
  longint unsigned edge_cnt = 0;

  ev_t             exp_q [$];
  ev_t             obs_q [$];
  longint unsigned exp_err_q [$];
  longint unsigned obs_err_q [$];

  // Reference model state
  logic [MAG_W-1:0] frm [N_BINS];
  longint unsigned  m_ram [N_BINS];
  int               m_bin = 0;
  bit               m_primed = 0;
  longint unsigned  m_acc = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every output event with the index of the edge that produced it
  always @(negedge clk) begin
    if (flux_valid) obs_q.push_back('{edge_cnt, 64'(flux)});
    if (frame_err)  obs_err_q.push_back(edge_cnt);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare recorded events against the model's expectations, then clear both
  task automatic flush_check(input string tag);
    int n;
    check({tag, "_npulse"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_pulse_edge"}, obs_q[i].at, exp_q[i].at);
      check({tag, "_flux"}, obs_q[i].val, exp_q[i].val);
    end
    check({tag, "_nerr"}, 64'(obs_err_q.size()), 64'(exp_err_q.size()));
    n = (obs_err_q.size() < exp_err_q.size()) ? obs_err_q.size() : exp_err_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_err_edge"}, obs_err_q[i], exp_err_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
    obs_err_q.delete();
    exp_err_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mag_valid = 1'b0;
      mag_sop   = 1'b0;
    end
  endtask

  // Drive the first nb bins of frm; optional random gaps between bins.
  // The model tracks frame position, previous-frame values and priming.
  task automatic send_frame(input int nb, input bit use_sop, input bit gaps);
    longint unsigned at;
    longint unsigned cur;
    int              tag;
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          mag_valid = 1'b0;
          mag_sop   = 1'b0;
        end
      end
      @(negedge clk);
      mag_valid = 1'b1;
      mag_sop   = (b == 0) && use_sop;
      mag_sq    = frm[b];
      at        = edge_cnt + 1;
      cur       = 64'(frm[b]);
      tag       = ((b == 0) && use_sop) ? 0 : m_bin;
      if ((b == 0) && use_sop && m_bin != 0) begin
        exp_err_q.push_back(at);
        m_primed = 0;
      end
      if (tag == 0) m_acc = 0;
      if (tag < SUM_BINS && cur > m_ram[tag]) m_acc += cur - m_ram[tag];
      m_ram[tag] = cur;
      if (tag == N_BINS - 1) begin
        if (m_primed) exp_q.push_back('{at + 3, m_acc});
        m_primed = 1;
      end
      m_bin = (tag + 1) % N_BINS;
    end
  endtask

  task automatic fill(input longint unsigned v);
    for (int b = 0; b < N_BINS; b++) frm[b] = MAG_W'(v);
  endtask

  task automatic fill_random;
    for (int b = 0; b < N_BINS; b++) begin
      if ($urandom_range(0, 3) == 0) frm[b] = MAG_W'({$urandom(), $urandom()});
      else                           frm[b] = MAG_W'($urandom_range(0, 5000));
    end
  endtask

  initial begin
    int nb;
    bit sop;
    for (int b = 0; b < N_BINS; b++) m_ram[b] = 0;
    reset     = 1'b1;
    mag_valid = 1'b0;
    mag_sop   = 1'b0;
    mag_sq    = '0;
    repeat (3) @(negedge clk);
    check("rst_flux", 64'(flux), 64'd0);
    check("rst_flux_valid", 64'(flux_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    idle(2);

    // Basic flux: seed frame emits nothing, then 4 bins x 50
    fill(100); send_frame(N_BINS, 1, 0);
    fill(150); send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("basic");
    check("basic_flux_hold", 64'(flux), 64'd200);

    // Rectification and masking of bins above SUM_BINS
    fill(100); send_frame(N_BINS, 1, 0);
    frm = '{33'd200, 33'd50, 33'd300, 33'd100, 33'd9999, 33'd9999, 33'd9999, 33'd9999};
    send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("rect");
    check("rect_flux_hold", 64'(flux), 64'd300);

    // Gapped input
    fill(100); send_frame(N_BINS, 1, 1);
    fill(150); send_frame(N_BINS, 1, 1);
    idle(6);
    flush_check("gap");
    check("gap_flux_hold", 64'(flux), 64'd200);

    // Mid-frame sop: abort after 5 bins, next full frame reseeds
    fill_random(); send_frame(N_BINS, 1, 0);
    fill_random(); send_frame(5, 1, 0);
    fill_random(); send_frame(N_BINS, 1, 0);
    fill_random(); send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("abort");

    // Reset during bin 3 with a nonzero flux held on the output
    fill(33'h1_0000_0000); send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("pre_rst");
    fill_random(); send_frame(3, 1, 0);
    @(negedge clk);
    reset     = 1'b1;
    mag_valid = 1'b1;
    mag_sop   = 1'b0;
    mag_sq    = frm[3];
    @(negedge clk);
    check("midrst_flux", 64'(flux), 64'd0);
    check("midrst_flux_valid", 64'(flux_valid), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    reset     = 1'b0;
    mag_valid = 1'b0;
    m_bin     = 0;
    m_primed  = 0;
    m_acc     = 0;
    idle(2);
    fill_random(); send_frame(N_BINS, 1, 0);
    fill_random(); send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("post_rst");

    // Width extremes
    fill(0); send_frame(N_BINS, 1, 0);
    fill((64'd1 << MAG_W) - 1); send_frame(N_BINS, 1, 0);
    idle(6);
    flush_check("wide");
    check("wide_flux_hold", 64'(flux), 4 * ((64'd1 << MAG_W) - 1));

    // Randomized frames, optional sop on natural wraps, gaps and aborts
    for (int i = 0; i < 40; i++) begin
      fill_random();
      if (m_bin == 0 && $urandom_range(0, 7) == 0) begin
        nb  = $urandom_range(3, N_BINS - 1);
        sop = 1;
      end else begin
        nb  = N_BINS;
        sop = (m_bin != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      send_frame(nb, sop, 1'($urandom_range(0, 1)));
    end
    if (m_bin != 0) begin
      fill_random();
      send_frame(N_BINS, 1, 0);
    end
    idle(6);
    flush_check("rnd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
